// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, divider op codes and divider FSM states
//   DIV_WIDTH      default operand/result width
//   ALUFN_DIV_GRP  alufn[5:2] value that routes an op to the divider
//   div_op_t       alufn[1:0] op select (DIVU, REMU, DIV, REM)
//   div_state_t    divider FSM states
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [3:0] ALUFN_DIV_GRP = 4'b0011;

  typedef enum logic [1:0] {
    OP_DIVU = 2'b00,
    OP_REMU = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } div_state_t;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == OP_REMU) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/divide_unit_if.sv
// rtl/divide_unit_if.sv - request/result bundle between the ALU and the divider
//   master (ALU side):    drives start, alufn, a, b; observes busy, done, otp, zero, div_by_zero, overflow
//   slave (divider side): the reverse
interface divide_unit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic [1:0]       alufn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] otp;
  logic             zero;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, alufn, a, b,
    input  busy, done, otp, zero, div_by_zero, overflow
  );

  modport slave (
    input  start, alufn, a, b,
    output busy, done, otp, zero, div_by_zero, overflow
  );

endinterface

// File: rtl/count_leading_zeros.sv
// rtl/count_leading_zeros.sv - combinational leading-zero count
//   value_i  WIDTH-bit input word
//   count_o  number of zero bits above the highest set bit (WIDTH when value_i == 0)
module count_leading_zeros #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]           value_i,
  output logic [$clog2(WIDTH+1)-1:0] count_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value_i[i]) begin
        count_o = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/divide_unit.sv
// rtl/divide_unit.sv - multi-cycle restoring radix-2 divider (DIVU/REMU/DIV/REM)
//   clk, rst  rising-edge clock, asynchronous active-high reset
//   bus       divide_unit_if.slave: start/alufn/a/b in; busy/done/otp/zero/div_by_zero/overflow out
//   EARLY_EXIT_EN  when defined, skips the leading zeros of |a| so latency is 2 + WIDTH - clz(|a|)
module divide_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic           clk,
  input logic           rst,
  divide_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] otp_q, otp_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             op_signed;
  logic             op_rem;
  logic [WIDTH-1:0] amag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;

  logic             load_res;
  logic             res_dbz;
  logic [WIDTH-1:0] res_val;

  assign op_signed = is_signed_op(op_q);
  assign op_rem    = is_rem_op(op_q);
  // Negating MIN yields MIN, which is the correct unsigned magnitude.
  assign amag      = (op_signed && a_q[WIDTH-1]) ? -a_q : a_q;

  // The shifted partial remainder can reach 2*|b|-1, so it needs one extra bit.
  // A clear top bit after the subtract means no borrow, i.e. rem_shift >= |b|.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, bmag_q};
  assign q_bit     = ~rem_diff[WIDTH];
  assign rem_next  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign dvd_next  = {dvd_q[WIDTH-2:0], q_bit};

`ifdef EARLY_EXIT_EN
  logic [$clog2(WIDTH+1)-1:0] lead_zeros;

  count_leading_zeros #(
    .WIDTH (WIDTH)
  ) u_clz (
    .value_i (amag),
    .count_o (lead_zeros)
  );
`endif

  function automatic logic [WIDTH-1:0] fix_sign(input logic             rem_sel,
                                                input logic [WIDTH-1:0] quo,
                                                input logic [WIDTH-1:0] rmd,
                                                input logic             quo_neg,
                                                input logic             rmd_neg);
    if (rem_sel) begin
      return rmd_neg ? -rmd : rmd;
    end
    return quo_neg ? -quo : quo;
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    bmag_d   = bmag_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    otp_d    = otp_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    load_res = 1'b0;
    res_dbz  = 1'b0;
    res_val  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.alufn;
          state_d = PREP;
        end
      end

      PREP: begin
        bmag_d = (op_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        qneg_d = op_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d = op_signed & a_q[WIDTH-1];
        rem_d  = '0;
`ifdef EARLY_EXIT_EN
        dvd_d  = amag << lead_zeros;
        cnt_d  = CW'(WIDTH - 1 - int'(lead_zeros));
`else
        dvd_d  = amag;
        cnt_d  = CW'(WIDTH - 1);
`endif
        if (b_q == '0) begin
          state_d  = FIN;
          load_res = 1'b1;
          res_dbz  = 1'b1;
          res_val  = op_rem ? a_q : '1;
        end
`ifdef EARLY_EXIT_EN
        else if (amag == '0) begin
          state_d  = FIN;
          load_res = 1'b1;
          res_val  = '0;
        end
`endif
        else begin
          state_d = CALC;
        end
      end

      CALC: begin
        rem_d = rem_next;
        dvd_d = dvd_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = FIN;
          load_res = 1'b1;
          res_val  = fix_sign(op_rem, dvd_next, rem_next, qneg_q, rneg_q);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Result and flags are captured on the edge that enters FIN.
    if (load_res) begin
      otp_d  = res_val;
      zero_d = (res_val == '0);
      dbz_d  = res_dbz;
      ovf_d  = op_signed && (a_q == MIN_VAL) && (b_q == '1);
    end

    busy_d = (state_d == PREP) || (state_d == CALC);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      bmag_q <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      otp_q  <= '0;
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      bmag_q <= bmag_d;
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      otp_q  <= otp_d;
      zero_q <= zero_d;
      dbz_q  <= dbz_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.otp         = otp_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_divide_unit.sv
// tb/tb_divide_unit.sv - self-checking bench for divide_unit (vector table, corner sequences, random ops)
module tb_divide_unit;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int MAX_WAIT = 60;
  localparam int N_RANDOM = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  divide_unit_if #(.WIDTH(W)) bus ();

  divide_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    int          lat_fixed;
    int          lat_early;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values; latency from the bit length of |a|.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dbz, output logic ovf, output int lat);
    longint sa, sb;
    longint unsigned mag;
    int bits;
    logic sgn, remop;
    sgn   = (op == OP_DIV) || (op == OP_REM);
    remop = (op == OP_REMU) || (op == OP_REM);
    sa    = longint'(signed'(a));
    sb    = longint'(signed'(b));
    dbz   = (b == 32'd0);
    ovf   = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (dbz) begin
      res = remop ? a : 32'hFFFF_FFFF;
    end else if (sgn) begin
      res = remop ? 32'(sa % sb) : 32'(sa / sb);
    end else begin
      res = remop ? (a % b) : (a / b);
    end
    mag  = (sgn && sa < 0) ? longint'(-sa) : {32'd0, a};
    bits = 0;
    while (mag != 0) begin
      bits++;
      mag = mag >> 1;
    end
    if (dbz) begin
      lat = 2;
    end else begin
`ifdef EARLY_EXIT_EN
      lat = 2 + bits;
`else
      lat = W + 2;
`endif
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic edbz, input logic eovf,
                        input int elat, input string tag);
    int cyc;
    logic seen;
    logic busy_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.alufn = op;
    bus.a     = a;
    bus.b     = b;
    busy_ok   = (bus.busy === 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.alufn = 2'($urandom);
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= MAX_WAIT) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".latency"}, 64'(cyc), 64'(elat));
    check({tag, ".busy"}, 64'(busy_ok && (bus.busy === 1'b0)), 64'd1);
    check({tag, ".otp"}, 64'(bus.otp), 64'(er));
    check({tag, ".zero"}, 64'(bus.zero), 64'(er == 32'd0));
    check({tag, ".div_by_zero"}, 64'(bus.div_by_zero), 64'(edbz));
    check({tag, ".overflow"}, 64'(bus.overflow), 64'(eovf));
  endtask

  initial begin
    logic [31:0] er, ra, rb, a_mid;
    logic        ed, eo, seen_done, bad;
    logic [1:0]  rop;
    int          el, sel;

    bus.start = 1'b0;
    bus.alufn = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    tbl.push_back('{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0, 34, 9});
    tbl.push_back('{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0, 1'b0, 34, 9});
    tbl.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1, 34, 34});
    tbl.push_back('{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0, 2, 2});
    tbl.push_back('{OP_REMU, 32'd5,          32'd0,          32'd5,          1'b1, 1'b0, 2, 2});
    tbl.push_back('{OP_DIVU, 32'd1,          32'd1,          32'd1,          1'b0, 1'b0, 34, 3});
    tbl.push_back('{OP_DIVU, 32'd9,          32'd3,          32'd3,          1'b0, 1'b0, 34, 6});
    tbl.push_back('{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, 1'b0, 34, 9});
    tbl.push_back('{OP_REMU, 32'd6,          32'd3,          32'd0,          1'b0, 1'b0, 34, 5});
    tbl.push_back('{OP_DIVU, 32'd0,          32'd5,          32'd0,          1'b0, 1'b0, 34, 2});
    tbl.push_back('{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  1'b0, 1'b0, 34, 34});
    tbl.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          1'b0, 1'b0, 34, 34});
    tbl.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 1'b0, 34, 5});
    tbl.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 1'b0, 34, 5});
    tbl.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1, 34, 34});
    tbl.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1, 1'b0, 2, 2});
    tbl.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0, 2, 2});

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.otp", 64'(bus.otp), 64'd0);
    check("reset.zero", 64'(bus.zero), 64'd0);
    check("reset.div_by_zero", 64'(bus.div_by_zero), 64'd0);
    check("reset.overflow", 64'(bus.overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("group_const", 64'({ALUFN_DIV_GRP, 2'b00}), 64'(6'b001100));

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
`ifdef EARLY_EXIT_EN
      el = tbl[i].lat_early;
`else
      el = tbl[i].lat_fixed;
`endif
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].dbz, tbl[i].ovf, el,
             $sformatf("tbl%0d", i));
    end

    // Result held after done; start presented during FIN is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.alufn = OP_DIVU; bus.a = 32'd6; bus.b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("fin.done", 64'(bus.done), 64'd1);
    bus.start = 1'b1; bus.alufn = OP_REMU; bus.a = 32'd8; bus.b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("fin.start_ignored_busy", 64'({bus.busy, bus.done}), 64'd0);
    check("fin.otp_held", 64'(bus.otp), 64'hFFFF_FFFF);
    @(negedge clk);
    check("fin.still_idle", 64'({bus.busy, bus.done}), 64'd0);
    check("fin.dbz_held", 64'(bus.div_by_zero), 64'd1);

    // Second start while busy, then reset mid-operation
`ifdef EARLY_EXIT_EN
    a_mid = 32'hF000_0009;
`else
    a_mid = 32'd9;
`endif
    @(negedge clk);
    bus.start = 1'b1; bus.alufn = OP_DIVU; bus.a = a_mid; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    seen_done = 1'b0;
    bad = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      if (bus.busy !== 1'b1) bad = 1'b1;
      if (cyc == 9) begin
        bus.start = 1'b1; bus.alufn = OP_REMU; bus.a = 32'd0; bus.b = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("midop.busy_held", 64'(bad), 64'd0);
    rst = 1'b1;
    #1;
    check("midop.rst_outputs",
          64'({bus.busy, bus.done, bus.otp, bus.zero, bus.div_by_zero, bus.overflow}), 64'd0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if ({bus.busy, bus.done, bus.otp, bus.zero, bus.div_by_zero, bus.overflow} !== '0) bad = 1'b1;
    end
    check("midop.rst_held", 64'(bad), 64'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    check("midop.no_done", 64'(seen_done), 64'd0);
    model(OP_DIVU, 32'd9, 32'd3, er, ed, eo, el);
    run_op(OP_DIVU, 32'd9, 32'd3, er, ed, eo, el, "after_rst");

    // Randomised ops against the reference model
    for (int n = 0; n < N_RANDOM; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: ra = $urandom_range(0, 300);
        4: ra = 32'd0;
        5: rb = ~32'($urandom_range(0, 7));
        default: ;
      endcase
      model(rop, ra, rb, er, ed, eo, el);
      run_op(rop, ra, rb, er, ed, eo, el, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
